// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: recovers 4-bit digit values from a multiplexed, active-low
// 4-digit seven-segment bus and delivers one frame per complete anode scan on
// a valid/ready output with per-digit error (and optional blank) flags.
// Optional feature macro: SEG_BLANK_EN -- when defined, an all-dark digit
// (seg_L = 1111111) is accepted as a legal blank; otherwise it is an error and
// out_blank stays 0.
module seg_scan_decoder #(
  parameter int unsigned STABLE_CYC = 4,
  parameter int unsigned CNT_W      = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  seg_L,
  input  logic [3:0]  an_L,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_digits,
  output logic [3:0]  out_err,
  output logic [3:0]  out_blank,
  output logic        overrun
);

  localparam int unsigned NDIG  = 4;
  localparam int unsigned DIG_W = 4;
  localparam int unsigned SEG_W = 7;
  localparam int unsigned SMP_W = NDIG + SEG_W;
  localparam int unsigned FRM_W = NDIG * DIG_W;
  localparam logic [CNT_W-1:0] STABLE = CNT_W'(STABLE_CYC);

  // Sample tracking state
  logic [SMP_W-1:0] prev_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Frame under assembly
  logic [FRM_W-1:0] slot_dig_q;
  logic [NDIG-1:0]  slot_err_q;
  logic [NDIG-1:0]  slot_blank_q;
  logic [NDIG-1:0]  mask_q;
  logic [FRM_W-1:0] slot_dig_d;
  logic [NDIG-1:0]  slot_err_d;
  logic [NDIG-1:0]  slot_blank_d;
  logic [NDIG-1:0]  mask_d;

  // Output-side next state
  logic             valid_d;
  logic [FRM_W-1:0] digits_d;
  logic [NDIG-1:0]  err_d;
  logic [NDIG-1:0]  blank_d;
  logic             overrun_d;

  // Combinational decode / control
  logic             an_valid_c;
  logic [1:0]       an_idx_c;
  logic             same_c;
  logic             capture_c;
  logic [DIG_W-1:0] dec_val_c;
  logic             dec_err_c;
  logic             dec_blank_c;
  logic             frame_done_c;
  logic             load_c;
  logic             accept_c;

  // Anode select: exactly one low line is a valid selection
  always_comb begin
    an_valid_c = 1'b0;
    an_idx_c   = 2'd0;
    case (an_L)
      4'b1110: begin an_valid_c = 1'b1; an_idx_c = 2'd0; end
      4'b1101: begin an_valid_c = 1'b1; an_idx_c = 2'd1; end
      4'b1011: begin an_valid_c = 1'b1; an_idx_c = 2'd2; end
      4'b0111: begin an_valid_c = 1'b1; an_idx_c = 2'd3; end
      default: begin an_valid_c = 1'b0; an_idx_c = 2'd0; end
    endcase
  end

  // Glyph decode of the current segment pattern
  always_comb begin
    dec_val_c   = 4'h0;
    dec_err_c   = 1'b0;
    dec_blank_c = 1'b0;
    case (seg_L)
      7'b1000000: dec_val_c = 4'h0;
      7'b1111001: dec_val_c = 4'h1;
      7'b0100100: dec_val_c = 4'h2;
      7'b0110000: dec_val_c = 4'h3;
      7'b0011001: dec_val_c = 4'h4;
      7'b0010010: dec_val_c = 4'h5;
      7'b0000010: dec_val_c = 4'h6;
      7'b1111000: dec_val_c = 4'h7;
      7'b0000000: dec_val_c = 4'h8;
      7'b0010000: dec_val_c = 4'h9;
      7'b0001000: dec_val_c = 4'hA;
      7'b0000011: dec_val_c = 4'hB;
      7'b1000110: dec_val_c = 4'hC;
      7'b0100001: dec_val_c = 4'hD;
      7'b0000110: dec_val_c = 4'hE;
      7'b0001110: dec_val_c = 4'hF;
`ifdef SEG_BLANK_EN
      7'b1111111: dec_blank_c = 1'b1;
`endif
      default:    dec_err_c = 1'b1;
    endcase
  end

  // Stability counter and single capture per dwell
  always_comb begin
    same_c = ({an_L, seg_L} == prev_q);
    if (same_c && an_valid_c) begin
      cnt_d = (cnt_q == STABLE) ? cnt_q : cnt_q + CNT_W'(1);
    end else begin
      cnt_d = an_valid_c ? CNT_W'(1) : CNT_W'(0);
    end
    // Saturated and unchanged means this dwell was already captured
    capture_c = an_valid_c && (cnt_d == STABLE) && !(same_c && (cnt_q == STABLE));
  end

  // Frame assembly, completion and output handshake
  always_comb begin
    slot_dig_d   = slot_dig_q;
    slot_err_d   = slot_err_q;
    slot_blank_d = slot_blank_q;
    mask_d       = mask_q;
    frame_done_c = 1'b0;
    if (capture_c) begin
      slot_dig_d[{an_idx_c, 2'b00} +: DIG_W] = dec_val_c;
      slot_err_d[an_idx_c]                   = dec_err_c;
      slot_blank_d[an_idx_c]                 = dec_blank_c;
      mask_d[an_idx_c]                       = 1'b1;
      if (mask_d == {NDIG{1'b1}}) begin
        frame_done_c = 1'b1;
        mask_d       = '0;
      end
    end

    accept_c  = out_valid && out_ready;
    load_c    = frame_done_c && (!out_valid || out_ready);
    overrun_d = frame_done_c && !load_c;

    valid_d  = out_valid;
    digits_d = out_digits;
    err_d    = out_err;
    blank_d  = out_blank;
    if (load_c) begin
      valid_d  = 1'b1;
      digits_d = slot_dig_d;
      err_d    = slot_err_d;
      blank_d  = slot_blank_d;
    end else if (accept_c) begin
      valid_d = 1'b0;
    end
  end

  // Sample tracking registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= {SMP_W{1'b1}};
      cnt_q  <= '0;
    end else begin
      prev_q <= {an_L, seg_L};
      cnt_q  <= cnt_d;
    end
  end

  // Partial-frame registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_dig_q   <= '0;
      slot_err_q   <= '0;
      slot_blank_q <= '0;
      mask_q       <= '0;
    end else begin
      slot_dig_q   <= slot_dig_d;
      slot_err_q   <= slot_err_d;
      slot_blank_q <= slot_blank_d;
      mask_q       <= mask_d;
    end
  end

  // Output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_digits <= '0;
      out_err    <= '0;
      out_blank  <= '0;
      overrun    <= 1'b0;
    end else begin
      out_valid  <= valid_d;
      out_digits <= digits_d;
      out_err    <= err_d;
      out_blank  <= blank_d;
      overrun    <= overrun_d;
    end
  end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Self-checking bench for seg_scan_decoder: directed scenarios plus a random
// scan stream compared against a run-length based reference model.
module tb_seg_scan_decoder;

  localparam int STABLE = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  seg_L;
  logic [3:0]  an_L;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_digits;
  logic [3:0]  out_err;
  logic [3:0]  out_blank;
  logic        overrun;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  seg_scan_decoder #(.STABLE_CYC(STABLE), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .seg_L(seg_L), .an_L(an_L),
    .out_valid(out_valid), .out_ready(out_ready), .out_digits(out_digits),
    .out_err(out_err), .out_blank(out_blank), .overrun(overrun)
  );

  logic [6:0] glyph [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                             7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                             7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                             7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  // Reference model state
  logic [10:0] m_last;
  int          m_run;
  logic [3:0]  m_mask;
  logic [3:0]  m_sdig [4];
  logic [3:0]  m_serr, m_sblank;
  logic        m_valid, m_overrun;
  logic [15:0] m_digits;
  logic [3:0]  m_err, m_blank;

  function automatic void model_reset();
    m_last = '1; m_run = 0; m_mask = '0;
    for (int i = 0; i < 4; i++) m_sdig[i] = '0;
    m_serr = '0; m_sblank = '0;
    m_valid = 1'b0; m_overrun = 1'b0; m_digits = '0; m_err = '0; m_blank = '0;
  endfunction

  function automatic void model_decode(input logic [6:0] s, output logic [3:0] v,
                                       output logic e, output logic b);
    v = 4'h0; e = 1'b1; b = 1'b0;
    for (int i = 0; i < 16; i++) if (glyph[i] == s) begin v = 4'(i); e = 1'b0; end
`ifdef SEG_BLANK_EN
    if (s == 7'h7F) begin e = 1'b0; b = 1'b1; end
`endif
  endfunction

  // One clock edge of the reference: run length of identical valid samples
  function automatic void model_step(input logic [3:0] a, input logic [6:0] s, input logic r);
    int zeros = 0;
    int idx = 0;
    logic ok, done, acc, e, b;
    logic [3:0] v;
    for (int i = 0; i < 4; i++) if (!a[i]) begin zeros++; idx = i; end
    ok = (zeros == 1);
    if (ok && ({a, s} == m_last)) begin
      if (m_run < 1000) m_run++;
    end else begin
      m_run = ok ? 1 : 0;
    end
    m_last = {a, s};
    m_overrun = 1'b0;
    acc = m_valid && r;
    done = 1'b0;
    if (ok && m_run == STABLE) begin
      model_decode(s, v, e, b);
      m_sdig[idx] = v; m_serr[idx] = e; m_sblank[idx] = b; m_mask[idx] = 1'b1;
      if (m_mask == 4'hF) begin done = 1'b1; m_mask = '0; end
    end
    if (done && (!m_valid || r)) begin
      m_valid = 1'b1;
      m_digits = {m_sdig[3], m_sdig[2], m_sdig[1], m_sdig[0]};
      m_err = m_serr; m_blank = m_sblank;
    end else begin
      if (done) m_overrun = 1'b1;
      if (acc) m_valid = 1'b0;
    end
  endfunction

  task automatic cycle(input logic [3:0] a, input logic [6:0] s, input logic r);
    an_L = a; seg_L = s; out_ready = r;
    @(posedge clk);
    model_step(a, s, r);
    #1;
  endtask

  task automatic dwell(input int d, input logic [6:0] s, input int n, input logic r);
    logic [3:0] a;
    a = ~(4'b0001 << d);
    repeat (n) cycle(a, s, r);
  endtask

  task automatic idle(input int n, input logic r);
    repeat (n) cycle(4'hF, 7'h7F, r);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; an_L = 4'hF; seg_L = 7'h7F; out_ready = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    n_checks++; if (out_digits !== 16'h0) begin n_fail++; $display("FAIL reset_digits: got %h want 0000", out_digits); end
    n_checks++; if (out_err !== 4'h0) begin n_fail++; $display("FAIL reset_err: got %b want 0000", out_err); end
    n_checks++; if (out_blank !== 4'h0) begin n_fail++; $display("FAIL reset_blank: got %b want 0000", out_blank); end
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b want 0", overrun); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic_scan();
    idle(2, 1'b1);
    dwell(0, glyph[1], 4, 1'b1);
    dwell(1, glyph[2], 4, 1'b1);
    dwell(2, glyph[3], 4, 1'b1);
    dwell(3, glyph[4], 3, 1'b1);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_pre_valid: got %b want 0", out_valid); end
    cycle(4'b0111, glyph[4], 1'b1);
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid: got %b want 1", out_valid); end
    n_checks++; if (out_digits !== 16'h4321) begin n_fail++; $display("FAIL basic_digits: got %h want 4321", out_digits); end
    n_checks++; if (out_err !== 4'h0) begin n_fail++; $display("FAIL basic_err: got %b want 0000", out_err); end
    cycle(4'b0111, glyph[4], 1'b1);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_accepted: got %b want 0", out_valid); end
  endtask

  task automatic test_short_dwell();
    idle(2, 1'b1);
    dwell(0, glyph[9], 3, 1'b1);
    dwell(1, glyph[8], 4, 1'b1);
    dwell(2, glyph[7], 4, 1'b1);
    dwell(3, glyph[6], 4, 1'b1);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL short_no_frame: got %b want 0", out_valid); end
    dwell(0, glyph[9], 4, 1'b1);
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL short_valid: got %b want 1", out_valid); end
    n_checks++; if (out_digits !== 16'h6789) begin n_fail++; $display("FAIL short_digits: got %h want 6789", out_digits); end
    idle(1, 1'b1);
  endtask

  task automatic test_overrun();
    idle(2, 1'b1);
    dwell(0, glyph[10], 4, 1'b0);
    dwell(1, glyph[11], 4, 1'b0);
    dwell(2, glyph[12], 4, 1'b0);
    dwell(3, glyph[13], 4, 1'b0);
    n_checks++; if (out_digits !== 16'hDCBA || out_valid !== 1'b1) begin n_fail++; $display("FAIL ovr_first: got %b/%h want 1/dcba", out_valid, out_digits); end
    dwell(0, glyph[5], 4, 1'b0);
    dwell(1, glyph[6], 4, 1'b0);
    dwell(2, glyph[7], 4, 1'b0);
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_early: got %b want 0", overrun); end
    dwell(3, glyph[8], 4, 1'b0);
    n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_pulse: got %b want 1", overrun); end
    n_checks++; if (out_digits !== 16'hDCBA || out_valid !== 1'b1) begin n_fail++; $display("FAIL ovr_held: got %b/%h want 1/dcba", out_valid, out_digits); end
    idle(1, 1'b0);
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_single: got %b want 0", overrun); end
    n_checks++; if (out_digits !== 16'hDCBA) begin n_fail++; $display("FAIL ovr_still: got %h want dcba", out_digits); end
    idle(1, 1'b1);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL ovr_accept: got %b want 0", out_valid); end
  endtask

  task automatic test_err();
    idle(2, 1'b1);
    dwell(0, glyph[0], 4, 1'b1);
    dwell(1, glyph[1], 4, 1'b1);
    dwell(2, 7'b1010101, 4, 1'b1);
    dwell(3, glyph[2], 4, 1'b1);
    n_checks++; if (out_err !== 4'b0100) begin n_fail++; $display("FAIL err_bits: got %b want 0100", out_err); end
    n_checks++; if (out_digits !== 16'h2010) begin n_fail++; $display("FAIL err_digits: got %h want 2010", out_digits); end
    idle(1, 1'b1);
  endtask

  task automatic test_invalid_an();
    idle(2, 1'b1);
    dwell(0, glyph[5], 4, 1'b1);
    dwell(1, glyph[6], 4, 1'b1);
    repeat (10) cycle(4'b1100, glyph[7], 1'b1);
    dwell(2, glyph[7], 4, 1'b1);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL inv_no_frame: got %b want 0", out_valid); end
    dwell(3, glyph[8], 4, 1'b1);
    n_checks++; if (out_valid !== 1'b1 || out_digits !== 16'h8765) begin n_fail++; $display("FAIL inv_frame: got %b/%h want 1/8765", out_valid, out_digits); end
    idle(1, 1'b1);
  endtask

  task automatic test_blank();
    idle(2, 1'b1);
    dwell(0, glyph[1], 4, 1'b1);
    dwell(1, glyph[2], 4, 1'b1);
    dwell(2, glyph[3], 4, 1'b1);
    dwell(3, 7'h7F, 4, 1'b1);
    n_checks++; if (out_digits !== 16'h0321) begin n_fail++; $display("FAIL blank_digits: got %h want 0321", out_digits); end
`ifdef SEG_BLANK_EN
    n_checks++; if (out_blank !== 4'b1000 || out_err !== 4'b0000) begin n_fail++; $display("FAIL blank_flags: got b=%b e=%b want b=1000 e=0000", out_blank, out_err); end
`else
    n_checks++; if (out_blank !== 4'b0000 || out_err !== 4'b1000) begin n_fail++; $display("FAIL blank_flags: got b=%b e=%b want b=0000 e=1000", out_blank, out_err); end
`endif
    idle(1, 1'b1);
  endtask

  task automatic test_reset_mid();
    idle(2, 1'b1);
    dwell(0, glyph[1], 4, 1'b0);
    dwell(1, glyph[1], 4, 1'b0);
    dwell(2, glyph[1], 4, 1'b0);
    dwell(3, glyph[1], 4, 1'b0);
    dwell(0, glyph[2], 4, 1'b0);
    dwell(1, glyph[2], 4, 1'b0);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    n_checks++; if (out_valid !== 1'b0 || out_digits !== 16'h0) begin n_fail++; $display("FAIL rmid_outputs: got %b/%h want 0/0000", out_valid, out_digits); end
    @(negedge clk);
    rst_n = 1'b1;
    dwell(2, glyph[2], 4, 1'b1);
    dwell(3, glyph[2], 4, 1'b1);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_mask_cleared: got %b want 0", out_valid); end
    idle(1, 1'b1);
  endtask

  task automatic test_random();
    logic [3:0] a;
    logic [6:0] s;
    int len;
    idle(2, 1'b1);
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 99) < 85) a = ~(4'b0001 << $urandom_range(0, 3));
      else a = 4'($urandom_range(0, 15)) & 4'b1010;
      case ($urandom_range(0, 9))
        0:       s = 7'h7F;
        1:       s = 7'($urandom);
        default: s = glyph[$urandom_range(0, 15)];
      endcase
      len = $urandom_range(1, 6);
      for (int c = 0; c < len; c++) begin
        cycle(a, s, ($urandom_range(0, 9) < 7));
        n_checks++; if (out_valid !== m_valid) begin n_fail++; $display("FAIL rnd_valid @%0t: got %b want %b", $time, out_valid, m_valid); end
        n_checks++; if (overrun !== m_overrun) begin n_fail++; $display("FAIL rnd_overrun @%0t: got %b want %b", $time, overrun, m_overrun); end
        n_checks++; if (out_digits !== m_digits) begin n_fail++; $display("FAIL rnd_digits @%0t: got %h want %h", $time, out_digits, m_digits); end
        n_checks++; if (out_err !== m_err) begin n_fail++; $display("FAIL rnd_err @%0t: got %b want %b", $time, out_err, m_err); end
        n_checks++; if (out_blank !== m_blank) begin n_fail++; $display("FAIL rnd_blank @%0t: got %b want %b", $time, out_blank, m_blank); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_scan();
    test_short_dwell();
    test_overrun();
    test_err();
    test_invalid_an();
    test_blank();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seg_scan_decoder.md
Name: seg_scan_decoder

Overview:
- Receive-side counterpart of the hex-to-seven-segment encoder.
- Watches a time-multiplexed 4-digit, active-low seven-segment bus (segments plus anode selects) and recovers the displayed 4-bit values per digit.
- Assembles one frame per complete anode scan and presents it on a valid/ready output with per-digit error flags.
- Used as a self-check / loopback monitor on display drivers and adder-result displays.

Parameters:
- STABLE_CYC, 4: consecutive identical samples required before a digit is captured (legal range 1..255).
- CNT_W, 8: width of the stability counter; must hold STABLE_CYC.

Ports:
- clk  in  1  system clock; all inputs synchronous to it.
- rst_n  in  1  asynchronous active-low reset.
- seg_L  in  7  segment lines, active-low, bit6=g .. bit0=a.
- an_L  in  4  digit anode selects, active-low; exactly one low = valid selection.
- out_valid  out  1  frame available.
- out_ready  in  1  consumer accepts frame when out_valid&&out_ready at a rising edge.
- out_digits  out  16  digit i in [4i+3:4i], i = anode index.
- out_err  out  4  bit i set = digit i pattern not a legal hex glyph.
- out_blank  out  4  bit i set = digit i captured as blank (SEG_BLANK_EN only, else 0).
- overrun  out  1  single-cycle pulse: completed frame dropped.

Behaviour:
- Reset (async assert, sync release): out_valid=0, out_digits=0, out_err=0, out_blank=0, overrun=0, capture mask=0, stability counter=0, previous-sample registers=all ones.
- Sample tracking:
  - Each cycle compare {an_L,seg_L} to the previous cycle's value.
  - If equal and an_L is one-hot-low, counter increments, saturating at STABLE_CYC.
  - Otherwise counter restarts at 1 if an_L is valid, else 0.
- Capture:
  - Exactly once per dwell, on the edge where the counter reaches STABLE_CYC.
  - STABLE_CYC=1 captures on the first valid cycle.
  - An invalid an_L (0000 or more than one low) never captures.
- Decode table (seg_L -> value):
  - 1000000->0, 1111001->1, 0100100->2, 0110000->3
  - 0011001->4, 0010010->5, 0000010->6, 1111000->7
  - 0000000->8, 0010000->9, 0001000->A, 0000011->B
  - 1000110->C, 0100001->D, 0000110->E, 0001110->F
  - Any other pattern: value 0, err bit set.
- Frame assembly:
  - A capture writes the slot's digit/err/blank and sets its mask bit.
  - Recapturing a slot before the frame completes overwrites it (latest wins).
- Frame completion: when the mask becomes 1111, the mask clears that cycle.
  - If the output buffer is empty, or is being consumed that same cycle, the frame loads into the output registers.
  - The next cycle shows out_valid=1, so capture-to-valid latency is 1 cycle.
  - Otherwise the frame is discarded, overrun pulses for 1 cycle, and the held output is untouched.
- Handshake:
  - out_valid stays high and outputs stay stable until accepted.
  - Acceptance without a simultaneous load clears out_valid next cycle.
  - Simultaneous accept and load keeps out_valid=1 with the new data.
- Reset mid-frame discards the partial mask and any pending output.

Optional Feature:
- SEG_BLANK_EN defined:
  - seg_L=1111111 is a legal blank: value 0, err=0, blank bit set.
- SEG_BLANK_EN undefined:
  - 1111111 is an illegal pattern: err set.
  - out_blank is tied to 0.

Test Plan:
- Scan anodes 1110,1101,1011,0111 with glyphs 1,2,3,4, 4 cycles each, out_ready=1, STABLE_CYC=4 -> out_digits=16'h4321, out_err=0, out_valid high 1 cycle after the 4th capture.
- Digit 0 dwell of only 3 cycles, then the remaining digits -> no frame until digit 0 has a 4-cycle dwell.
- out_ready=0; complete two scans (A,B,C,D then 5,6,7,8) -> first frame 16'hDCBA held; overrun pulses once at second completion; raise out_ready -> 16'hDCBA accepted, then out_valid=0.
- seg_L=1010101 on digit 2 within a full scan -> out_err=4'b0100, digit 2 value 0.
- an_L=1100 held 10 cycles between valid dwells -> no captures, mask unchanged.
- seg_L=1111111 on digit 3 -> SEG_BLANK_EN: out_blank=4'b1000, out_err=0; without the macro: out_err=4'b1000, out_blank=0.
